// File: rtl/pe_pkg.sv
// pe_pkg: shared FSM encodings, default parameters and accumulator bound helper
package pe_pkg;
    localparam logic [0:0] S_EMPTY  = 1'b0;
    localparam logic [0:0] S_LOADED = 1'b1;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 24;
    localparam bit SAT_DEF    = 1'b1;
    function automatic logic [63:0] acc_hi(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction
endpackage

// File: rtl/pe_sat_add.sv
// pe_sat_add: W+1-bit signed add with clamp or wrap and overflow flag
module pe_sat_add
    import pe_pkg::*;
#(
    parameter int W   = ACC_W_DEF,
    parameter bit SAT = SAT_DEF
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y,
    output logic                ovf
);
    localparam logic [63:0] HI = acc_hi(W);
    logic [W:0] s;
    assign s   = {a[W-1], a} + {b[W-1], b};
    assign ovf = s[W] ^ s[W-1];
    assign y   = (SAT && ovf) ? (s[W] ? ~HI[W-1:0] : HI[W-1:0]) : s[W-1:0];
endmodule

// File: rtl/pe_ws.sv
// pe_ws: weight-stationary systolic PE with double-buffered weight and shift-chain load
module pe_ws
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter bit SAT    = SAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic                     in_valid,
    input  logic signed [ACC_W-1:0]  in_acc,
    input  logic signed [DATA_W-1:0] in_w,
    input  logic                     in_w_valid,
    input  logic                     in_w_swap,
    input  logic                     clr_ovf,
    output logic signed [DATA_W-1:0] out_a,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic signed [DATA_W-1:0] out_w,
    output logic                     out_w_valid,
    output logic                     out_w_swap,
    output logic                     shadow_full,
    output logic                     ovf
);
    logic signed [DATA_W-1:0]   w_act, w_shadow;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_x, sum;
    logic                       sum_ovf;
    logic [0:0]                 state;

    assign prod        = in_a * w_act;
    assign prod_x      = ACC_W'(prod);
    assign shadow_full = state == S_LOADED;

    pe_sat_add #(.W(ACC_W), .SAT(SAT)) u_add (
        .a  (in_acc),
        .b  (prod_x),
        .y  (sum),
        .ovf(sum_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_a       <= '0;
            out_valid   <= 1'b0;
            out_acc     <= '0;
            out_w       <= '0;
            out_w_valid <= 1'b0;
            out_w_swap  <= 1'b0;
            ovf         <= 1'b0;
            w_act       <= '0;
            w_shadow    <= '0;
            state       <= S_EMPTY;
        end else begin
            out_valid   <= in_valid;
            out_w_valid <= in_w_valid;
            out_w_swap  <= in_w_swap;
            if (in_valid) begin
                out_a   <= in_a;
                out_acc <= sum;
            end
            ovf <= (in_valid && sum_ovf) || (ovf && !clr_ovf);
            if (in_w_valid) begin
                w_shadow <= in_w;
                out_w    <= w_shadow;
            end
            // an empty shadow is never promoted, so a stray swap keeps the live weight
            if (in_w_swap && state == S_LOADED) w_act <= w_shadow;
            state <= in_w_valid ? S_LOADED : in_w_swap ? S_EMPTY : state;
        end
    end
endmodule

// File: tb/tb_pe_ws.sv
// tb_pe_ws: directed checks of a saturating PE, a wrapping PE and a 4-PE weight column
module tb_pe_ws;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic signed [7:0]  a = '0, w = '0;
    logic signed [15:0] acc = '0;
    logic v = 1'b0, wv = 1'b0, ws = 1'b0, clr = 1'b0;

    logic signed [7:0]  s_a, s_w, r_a, r_w;
    logic signed [15:0] s_acc, r_acc;
    logic s_v, s_wv, s_ws, s_sf, s_ovf, r_v, r_wv, r_ws, r_sf, r_ovf;

    pe_ws #(.DATA_W(8), .ACC_W(16), .SAT(1'b1)) u_s (
        .clk(clk), .rst(rst), .in_a(a), .in_valid(v), .in_acc(acc), .in_w(w),
        .in_w_valid(wv), .in_w_swap(ws), .clr_ovf(clr), .out_a(s_a), .out_valid(s_v),
        .out_acc(s_acc), .out_w(s_w), .out_w_valid(s_wv), .out_w_swap(s_ws),
        .shadow_full(s_sf), .ovf(s_ovf)
    );
    pe_ws #(.DATA_W(8), .ACC_W(16), .SAT(1'b0)) u_w (
        .clk(clk), .rst(rst), .in_a(a), .in_valid(v), .in_acc(acc), .in_w(w),
        .in_w_valid(wv), .in_w_swap(ws), .clr_ovf(clr), .out_a(r_a), .out_valid(r_v),
        .out_acc(r_acc), .out_w(r_w), .out_w_valid(r_wv), .out_w_swap(r_ws),
        .shadow_full(r_sf), .ovf(r_ovf)
    );

    logic signed [7:0]  cw0 = '0, ca = '0;
    logic cwv0 = 1'b0, cws0 = 1'b0, cv = 1'b0;
    logic signed [7:0]  cw [0:4];
    logic               cwv [0:4];
    logic               cws [0:4];
    logic signed [7:0]  c_a [0:3];
    logic signed [15:0] c_acc [0:3];
    logic               c_v [0:3];
    logic               c_sf [0:3];
    logic               c_ovf [0:3];
    assign cw[0]  = cw0;
    assign cwv[0] = cwv0;
    assign cws[0] = cws0;

    for (genvar k = 0; k < 4; k++) begin : g_col
        pe_ws #(.DATA_W(8), .ACC_W(16), .SAT(1'b1)) u_c (
            .clk(clk), .rst(rst), .in_a(ca), .in_valid(cv), .in_acc(16'sd0), .in_w(cw[k]),
            .in_w_valid(cwv[k]), .in_w_swap(cws[k]), .clr_ovf(1'b0), .out_a(c_a[k]),
            .out_valid(c_v[k]), .out_acc(c_acc[k]), .out_w(cw[k+1]), .out_w_valid(cwv[k+1]),
            .out_w_swap(cws[k+1]), .shadow_full(c_sf[k]), .ovf(c_ovf[k])
        );
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_acc_async", int'(s_acc), 0);
        chk("rst_sf_async", int'(s_sf), 0);
        step();
        rst = 1'b1;
        repeat (5) step();
        chk("idle_a", int'(s_a), 0);
        chk("idle_v", int'(s_v), 0);
        chk("idle_acc", int'(s_acc), 0);
        chk("idle_w", int'(s_w), 0);
        chk("idle_wv", int'(s_wv), 0);
        chk("idle_ws", int'(s_ws), 0);
        chk("idle_sf", int'(s_sf), 0);
        chk("idle_ovf", int'(s_ovf), 0);
        chk("idle_col_sf", int'(c_sf[3]), 0);

        w = 8'sd3; wv = 1'b1;
        step();
        chk("push_sf", int'(s_sf), 1);
        chk("push_wv", int'(s_wv), 1);
        wv = 1'b0; ws = 1'b1; v = 1'b1; a = -8'sd5; acc = 16'sd100;
        step();
        chk("swap_mac_old_w", int'(s_acc), 100);
        chk("swap_sf", int'(s_sf), 0);
        chk("swap_fwd", int'(s_ws), 1);
        chk("swap_a", int'(s_a), -5);
        ws = 1'b0;
        step();
        chk("mac_new_w", int'(s_acc), 85);
        chk("mac_new_w_wrap", int'(r_acc), 85);
        v = 1'b0; acc = 16'sd555;
        step();
        chk("hold_acc", int'(s_acc), 85);
        chk("valid_low", int'(s_v), 0);

        w = 8'sd127; wv = 1'b1;
        step();
        wv = 1'b0; ws = 1'b1;
        step();
        ws = 1'b0; v = 1'b1; a = 8'sd127; acc = 16'sd32000;
        step();
        chk("sat_hi", int'(s_acc), 32767);
        chk("sat_hi_ovf", int'(s_ovf), 1);
        chk("wrap_hi", int'(r_acc), -17407);
        chk("wrap_hi_ovf", int'(r_ovf), 1);
        v = 1'b0; w = -8'sd128; wv = 1'b1;
        step();
        chk("chain_out_w", int'(s_w), 127);
        chk("ovf_sticky", int'(s_ovf), 1);
        wv = 1'b0; ws = 1'b1;
        step();
        ws = 1'b0; v = 1'b1; a = 8'sd127; acc = -16'sd32000;
        step();
        chk("sat_lo", int'(s_acc), -32768);
        chk("wrap_lo", int'(r_acc), 17280);
        v = 1'b0; clr = 1'b1;
        step();
        chk("clr_ovf_sat", int'(s_ovf), 0);
        chk("clr_ovf_wrap", int'(r_ovf), 0);
        v = 1'b1;
        step();
        chk("set_beats_clr", int'(s_ovf), 1);
        v = 1'b0;
        step();
        clr = 1'b0;
        chk("clr_again", int'(s_ovf), 0);

        w = 8'sd5; wv = 1'b1;
        step();
        w = 8'sd9; ws = 1'b1;
        step();
        chk("swap_push_sf", int'(s_sf), 1);
        chk("swap_push_out_w", int'(s_w), 5);
        wv = 1'b0; ws = 1'b0; v = 1'b1; a = 8'sd1; acc = 16'sd0;
        step();
        chk("swap_push_w_act", int'(s_acc), 5);
        v = 1'b0; ws = 1'b1;
        step();
        chk("swap_empties", int'(s_sf), 0);
        step();
        chk("swap_empty_fwd", int'(s_ws), 1);
        chk("swap_empty_sf", int'(s_sf), 0);
        ws = 1'b0; v = 1'b1;
        step();
        chk("swap_empty_keep", int'(s_acc), 9);

        cwv0 = 1'b1;
        cw0 = 8'sd10; step();
        cw0 = 8'sd20; step();
        cw0 = 8'sd30; step();
        cw0 = 8'sd40; step();
        cwv0 = 1'b0;
        chk("col_sf3_loaded", int'(c_sf[3]), 1);
        cws0 = 1'b1;
        step();
        cws0 = 1'b0;
        chk("skew0_pe0", int'(c_sf[0]), 0);
        chk("skew0_pe1", int'(c_sf[1]), 1);
        step();
        chk("skew1_pe1", int'(c_sf[1]), 0);
        chk("skew1_pe2", int'(c_sf[2]), 1);
        step();
        chk("skew2_pe2", int'(c_sf[2]), 0);
        chk("skew2_pe3", int'(c_sf[3]), 1);
        step();
        chk("skew3_pe3", int'(c_sf[3]), 0);
        cv = 1'b1; ca = 8'sd1;
        step();
        cv = 1'b0;
        chk("col_pe0", int'(c_acc[0]), 40);
        chk("col_pe1", int'(c_acc[1]), 30);
        chk("col_pe2", int'(c_acc[2]), 20);
        chk("col_pe3", int'(c_acc[3]), 10);

        v = 1'b1; a = 8'sd3; acc = 16'sd7;
        step();
        chk("pre_rst_acc", int'(s_acc), 34);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_acc", int'(s_acc), 0);
        chk("mid_rst_v", int'(s_v), 0);
        #1 rst = 1'b1;
        step();
        chk("post_rst_w0", int'(s_acc), 7);
        v = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pe_ws.md
# pe_ws

Parametrised weight-stationary systolic processing element, the successor of the fixed 8-bit MAC cell. Each PE holds an active weight and a double-buffered shadow weight. The shadow is loaded through a per-column shift chain while the array computes, and is promoted to active on a swap pulse that ripples with the data skew. Activations stream horizontally and partial sums vertically, each with a valid qualifier and selectable saturate or wrap accumulation.

## Interface
- DATA_W, 8: signed width of activation and weight.
- ACC_W, 24: signed width of partial sum. Must satisfy ACC_W ≥ 2·DATA_W.
- SAT, 1: 1 = saturate on overflow; 0 = two's-complement wrap.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_a  in  DATA_W  signed activation from the west.
- in_valid  in  1  qualifies in_a and in_acc.
- in_acc  in  ACC_W  signed partial sum from the north.
- in_w  in  DATA_W  weight from the north neighbour's chain.
- in_w_valid  in  1  shift-chain push.
- in_w_swap  in  1  promote shadow to active (pulse).
- clr_ovf  in  1  clear sticky overflow flag.
- out_a  out  DATA_W  registered in_a to the east.
- out_valid  out  1  registered in_valid.
- out_acc  out  ACC_W  registered partial sum to the south.
- out_w  out  DATA_W  previous shadow value to the south.
- out_w_valid  out  1  registered in_w_valid.
- out_w_swap  out  1  registered in_w_swap.
- shadow_full  out  1  shadow written since the last swap.
- ovf  out  1  sticky overflow flag.

## Operation
**Reset.** All outputs, w_act and w_shadow are 0. The FSM is in S_EMPTY.

**Data path.**
- When in_valid=1:
  - out_a ← in_a.
  - out_acc ← f(in_acc + in_a·w_act).
- When in_valid=0: out_a and out_acc hold their values.
- out_valid ← in_valid every cycle.

**Arithmetic.**
- Product is signed, 2·DATA_W bits.
- Sum is formed at ACC_W+1 bits with sign extension.
- Overflow means the sum is outside [−2^(ACC_W−1), 2^(ACC_W−1)−1].
- SAT=1: f clamps to the nearest bound. SAT=0: f keeps the low ACC_W bits.
- Overflow on a valid cycle sets ovf under either SAT setting.

**Sticky flag.** clr_ovf clears ovf. If a set and clr_ovf occur in the same cycle, the set wins.

**Weight chain.**
- On in_w_valid: w_shadow ← in_w and out_w ← old w_shadow.
- out_w_valid ← in_w_valid every cycle.
- Pushing N words into an N-deep column leaves word k (0-based, first pushed) in PE N−1−k.

**Swap.** On in_w_swap, w_act ← w_shadow (the value before any same-cycle push). out_w_swap ← in_w_swap every cycle.

**FSM (shadow tracking).**
- S_EMPTY → S_LOADED on in_w_valid.
- S_LOADED → S_EMPTY on in_w_swap without in_w_valid. S_LOADED stays in S_LOADED on swap+push.
- A swap in S_EMPTY leaves w_act unchanged but is still forwarded.
- shadow_full = (state == S_LOADED).

## Timing
- Latency of in → out is 1 cycle for a, valid, acc, w, w_valid and w_swap.
- A MAC in the same cycle as a swap uses the old w_act. The new weight applies from the next cycle.
- A push does not disturb w_act, so computation continues uninterrupted.
- An asserted rst mid-stream drops all in-flight data immediately and clears ovf and both weights. Operation resumes on the first edge after release.
- No backpressure: the upstream guarantees the skew. The PE never stalls.

## Structure
- Package pe_pkg holds:
  - FSM state localparams S_EMPTY and S_LOADED.
  - The ACC_W bound computation.
  - The default parameter values shared with the array top.
- One sub-module, pe_sat_add: combinational (ACC_W+1)-bit add with clamp or wrap per SAT and an overflow output. It is reused by the array-edge adder.
- Everything else stays in pe_ws. Target is about 150–250 lines.

## Test plan
All scenarios use DATA_W=8 and ACC_W=16.
- **Reset/idle:** hold rst low, release, drive in_valid=0 for 5 cycles → all outputs 0, shadow_full=0, ovf=0.
- **MAC and swap order:** push w=3, then swap, with in_a=−5, in_acc=100 valid on the swap cycle and the next cycle → out_acc=100 (old w_act=0), then 85.
- **Saturation, SAT=1:** w=127, in_a=127, in_acc=32000 → out_acc=32767, ovf=1. Then w=−128, in_a=127, in_acc=−32000 → out_acc=−32768. Pulse clr_ovf alone → ovf=0.
- **Wrap, SAT=0:** same first input → out_acc=−17407, ovf=1.
- **Chain in a 4-PE column:** push 10, 20, 30, 40, then swap propagated → PE0..PE3 active = 40, 30, 20, 10, with each swap one cycle after its predecessor.
- **Corner cases:**
  - swap+push together in S_LOADED → w_act gets the old shadow and the state stays S_LOADED.
  - swap in S_EMPTY → w_act unchanged.
  - clr_ovf together with an overflow → ovf=1.
